psum_accumulator: RTL



---
 rtl/psum_accumulator_if.sv | 34 +++
 rtl/psum_accumulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator_if.sv
// -----------------------------------------------------------------------------
// psum_accumulator_if
// Bundles the two data paths of the partial-sum accumulator:
//   - ofifo side : ofifo_valid, psum_in (show-ahead head word), ofifo_rd (pop)
//   - SRAM side  : mem_cen_n, mem_wen_n, mem_addr, mem_d (request), mem_q (read
//                  data, one cycle after a read)
// Modports:
//   master - the accumulator (consumes ofifo words, drives SRAM requests)
//   slave  - the environment (ofifo + SRAM)
// -----------------------------------------------------------------------------
interface psum_accumulator_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_w  = 4
);
   logic                       ofifo_valid;
   logic [psum_bw*col-1:0]     psum_in;
   logic                       ofifo_rd;
   logic                       mem_cen_n;
   logic                       mem_wen_n;
   logic [addr_w-1:0]          mem_addr;
   logic [psum_bw*col-1:0]     mem_d;
   logic [psum_bw*col-1:0]     mem_q;

   modport master (
      input  ofifo_valid, psum_in, mem_q,
      output ofifo_rd, mem_cen_n, mem_wen_n, mem_addr, mem_d
   );

   modport slave (
      output ofifo_valid, psum_in, mem_q,
      input  ofifo_rd, mem_cen_n, mem_wen_n, mem_addr, mem_d
   );
endinterface

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Drains the corelet ofifo and accumulates col-lane partial sums into the psum
// SRAM over num_pass kernel passes. Pass 0 writes each word straight through
// (1 word/cycle); later passes read the stored word, add the new word lane by
// lane (wrapping, no cross-lane carry) and write it back (2 cycles/word).
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   start      - one-cycle job start pulse, ignored while busy
//   bus        - ofifo + SRAM interface (master modport)
//   busy       - high in every state except idle
//   done       - one-cycle pulse after the final write of a job
// -----------------------------------------------------------------------------
module psum_accumulator #(
   parameter int col      = 8,
   parameter int psum_bw  = 16,
   parameter int num_out  = 16,
   parameter int num_pass = 9,
   parameter int addr_w   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   psum_accumulator_if.master    bus,
   output logic                  busy,
   output logic                  done
);
   localparam int word_w = psum_bw * col;
   localparam int pass_w = (num_pass > 1) ? $clog2(num_pass) : 1;
   localparam logic [addr_w-1:0] last_addr = addr_w'(num_out - 1);
   localparam logic [pass_w-1:0] last_pass = pass_w'((num_pass > 0) ? (num_pass - 1) : 0);
   localparam logic job_ok = (num_pass > 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      st_idle  = 3'd0,
      st_drain = 3'd1,
      st_rd    = 3'd2,
      st_acc   = 3'd3,
      st_done  = 3'd4
   } state_t;

   state_t              state_r, state_s;
   logic [addr_w-1:0]   addr_cnt_r, addr_cnt_s;
   logic [pass_w-1:0]   pass_cnt_r, pass_cnt_s;
   logic [word_w-1:0]   hold_r;
   logic                hold_en_s;
   logic                wr_step_s;

   // Lane-wise modular add: each lane wraps independently, carries never cross lanes.
   function automatic logic [word_w-1:0] lane_add(input logic [word_w-1:0] a,
                                                  input logic [word_w-1:0] b);
      logic [word_w-1:0] sum;
      sum = {word_w{1'b0}};
      for (int i = 0; i < col; i++) begin
         sum[i*psum_bw +: psum_bw] = a[i*psum_bw +: psum_bw] + b[i*psum_bw +: psum_bw];
      end
      return sum;
   endfunction

   // busy simply reflects any non-idle state.
   always_comb begin
      busy = (state_r != st_idle) ? 1'b1 : 1'b0;
   end

   // Next-state, counter and SRAM/ofifo control decode.
   always_comb begin
      state_s       = state_r;
      addr_cnt_s    = addr_cnt_r;
      pass_cnt_s    = pass_cnt_r;
      hold_en_s     = 1'b0;
      wr_step_s     = 1'b0;
      done          = 1'b0;
      bus.ofifo_rd  = 1'b0;
      bus.mem_cen_n = 1'b1;
      bus.mem_wen_n = 1'b1;
      bus.mem_addr  = addr_cnt_r;
      bus.mem_d     = {word_w{1'b0}};

      // While reset is held, keep the SRAM and ofifo untouched so an aborted
      // job neither pops a word nor disturbs stored partial sums.
      if (reset) begin
         state_s    = st_idle;
         addr_cnt_s = {addr_w{1'b0}};
         pass_cnt_s = {pass_w{1'b0}};
      end else begin
         case (state_r)
            st_idle: begin
               if (start && job_ok) begin
                  state_s    = st_drain;
                  addr_cnt_s = {addr_w{1'b0}};
                  pass_cnt_s = {pass_w{1'b0}};
               end else begin
                  state_s = st_idle;
               end
            end
            st_drain: begin
               if (bus.ofifo_valid) begin
                  bus.ofifo_rd  = 1'b1;
                  bus.mem_cen_n = 1'b0;
                  bus.mem_wen_n = 1'b0;
                  bus.mem_d     = bus.psum_in;
                  wr_step_s     = 1'b1;
                  state_s       = st_drain;
               end else begin
                  state_s = st_drain;
               end
            end
            st_rd: begin
               if (bus.ofifo_valid) begin
                  bus.ofifo_rd  = 1'b1;
                  bus.mem_cen_n = 1'b0;
                  bus.mem_wen_n = 1'b1;
                  hold_en_s     = 1'b1;
                  state_s       = st_acc;
               end else begin
                  state_s = st_rd;
               end
            end
            st_acc: begin
               // mem_q carries the word read in the preceding RD cycle.
               bus.mem_cen_n = 1'b0;
               bus.mem_wen_n = 1'b0;
               bus.mem_d     = lane_add(bus.mem_q, hold_r);
               wr_step_s     = 1'b1;
               state_s       = st_rd;
            end
            st_done: begin
               done    = 1'b1;
               state_s = st_idle;
            end
            default: begin
               state_s = st_idle;
            end
         endcase

         // Every write advances the address; the last address of a pass
         // either ends the job or opens the next accumulate pass.
         if (wr_step_s) begin
            if (addr_cnt_r == last_addr) begin
               addr_cnt_s = {addr_w{1'b0}};
               if (pass_cnt_r == last_pass) begin
                  state_s = st_done;
               end else begin
                  pass_cnt_s = pass_cnt_r + 1'b1;
                  state_s    = st_rd;
               end
            end else begin
               addr_cnt_s = addr_cnt_r + 1'b1;
            end
         end else begin
            addr_cnt_s = addr_cnt_s;
         end
      end
   end

   // State, counters and the ofifo word held across the RD->ACC pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= st_idle;
         addr_cnt_r <= {addr_w{1'b0}};
         pass_cnt_r <= {pass_w{1'b0}};
         hold_r     <= {word_w{1'b0}};
      end else begin
         state_r    <= state_s;
         addr_cnt_r <= addr_cnt_s;
         pass_cnt_r <= pass_cnt_s;
         if (hold_en_s) begin
            hold_r <= bus.psum_in;
         end else begin
            hold_r <= hold_r;
         end
      end
   end
endmodule
